// File: rtl/param_special_counter_if.sv
// Control/data bundle for param_special_counter: step, load, table-write
// controls toward the counter and its registered outputs back.
//
// Signal semantics (no back-pressure): every cycle is a transfer. A high en
// requests exactly one step at the next rising edge; load is a one-cycle
// strobe that wins over en; tbl_we writes tbl_data at tbl_addr at the same
// edge regardless of the other controls. q/tc/idx are registered and valid
// after every edge.
interface param_special_counter_if #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             en;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             tbl_we;
    logic [AW-1:0]    tbl_addr;
    logic [WIDTH-1:0] tbl_data;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic [AW-1:0]    idx;

    // Stimulus side: drives controls, observes the counter outputs.
    modport master (
        output en, mode, load, load_val, tbl_we, tbl_addr, tbl_data,
        input  q, tc, idx
    );

    // Counter side.
    modport slave (
        input  en, mode, load, load_val, tbl_we, tbl_addr, tbl_data,
        output q, tc, idx
    );
endinterface

// File: rtl/param_special_counter.sv
// Multi-mode counter: binary up, binary down, Gray up, or a programmable
// sequence table walked by an index. q, tc and idx are all registered;
// tc pulses for one cycle after a step that wraps.
module param_special_counter #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    param_special_counter_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_GRAY = 2'b10;
    localparam logic [1:0] MODE_TBL  = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] tbl_q [DEPTH];

    // Step candidates, one per mode.
    logic [WIDTH-1:0] gray_bin;
    logic [WIDTH-1:0] gray_bin_nxt;
    logic [AW-1:0]    idx_nxt;
    logic             idx_wrap;
    logic [WIDTH-1:0] tbl_rd;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray mode decodes whatever q holds (even a non-Gray loaded value)
    // and steps from its binary equivalent.
    always_comb begin
        gray_bin     = gray2bin(q_q);
        gray_bin_nxt = gray_bin + 1'b1;
    end

    // Table index advance and read. The read uses the registered table, so
    // a write to the same entry at the same edge is seen only on the next
    // pass. Index decode is a compare loop so out-of-range values select
    // nothing for non-power-of-two DEPTH.
    always_comb begin
        idx_wrap = (idx_q == AW'(DEPTH - 1));
        idx_nxt  = idx_wrap ? '0 : idx_q + 1'b1;
        tbl_rd   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx_nxt == AW'(i)) begin
                tbl_rd = tbl_q[i];
            end
        end
    end

    // Next-state selection: load > step > hold; tc only follows a wrapping step.
    always_comb begin
        q_d   = q_q;
        idx_d = idx_q;
        tc_d  = 1'b0;
        if (bus.load) begin
            q_d   = bus.load_val;
            idx_d = '0;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_UP: begin
                    q_d  = q_q + 1'b1;
                    tc_d = (q_q == {WIDTH{1'b1}});
                end
                MODE_DOWN: begin
                    q_d  = q_q - 1'b1;
                    tc_d = (q_q == '0);
                end
                MODE_GRAY: begin
                    q_d  = bin2gray(gray_bin_nxt);
                    tc_d = (gray_bin == {WIDTH{1'b1}});
                end
                MODE_TBL: begin
                    q_d   = tbl_rd;
                    idx_d = idx_nxt;
                    tc_d  = idx_wrap;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
    end

    // Counter state registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= '0;
            idx_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            q_q   <= q_d;
            idx_q <= idx_d;
            tc_q  <= tc_d;
        end
    end

    // Sequence table: identity on reset, written independently of counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= WIDTH'(i);
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.tbl_we && (bus.tbl_addr == AW'(i))) begin
                    tbl_q[i] <= bus.tbl_data;
                end
            end
        end
    end

    // Registered outputs.
    always_comb begin
        bus.q   = q_q;
        bus.tc  = tc_q;
        bus.idx = idx_q;
    end
endmodule

// File: tb/tb_param_special_counter.sv
// Testbench for param_special_counter (WIDTH=3, DEPTH=6 so that table
// addresses 6 and 7 are out of range). A reference model predicts every
// cycle's registered outputs; a monitor pops and compares them.
module tb_param_special_counter;
    localparam int W  = 3;
    localparam int D  = 6;
    localparam int AW = 3;
    localparam int N  = 1 << W;
    localparam int EW = W + 1 + AW;

    logic clk;
    logic rst;

    param_special_counter_if #(.WIDTH(W), .DEPTH(D)) bus ();

    param_special_counter #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard: {q, tc, idx} expected after each driven edge
    logic [EW-1:0] exp_q[$];

    // Reference model state
    int m_q, m_tc, m_idx;
    int m_tbl[D];

    function automatic int gray_of(input int k);
        return k ^ (k >> 1);
    endfunction

    // Position of a code in the Gray sequence 0..N-1
    function automatic int gray_pos(input int g);
        for (int k = 0; k < N; k++) begin
            if (gray_of(k) == g) return k;
        end
        return 0;
    endfunction

    function automatic void model_reset();
        m_q = 0;
        m_tc = 0;
        m_idx = 0;
        for (int i = 0; i < D; i++) m_tbl[i] = i % N;
    endfunction

    function automatic void model_step(input int e, input int m, input int ld, input int lv,
                                       input int we, input int a, input int d);
        int p;
        if (ld != 0) begin
            m_q = lv;
            m_idx = 0;
            m_tc = 0;
        end else if (e != 0) begin
            case (m)
                0: begin m_tc = (m_q == N - 1); m_q = (m_q + 1) % N; end
                1: begin m_tc = (m_q == 0); m_q = (m_q + N - 1) % N; end
                2: begin
                    p = gray_pos(m_q);
                    m_tc = (p == N - 1);
                    m_q = gray_of((p + 1) % N);
                end
                default: begin
                    m_idx = (m_idx + 1) % D;
                    m_tc = (m_idx == 0);
                    m_q = m_tbl[m_idx];
                end
            endcase
        end else begin
            m_tc = 0;
        end
        if (we != 0 && a < D) m_tbl[a] = d;
        exp_q.push_back({W'(m_q), m_tc[0], AW'(m_idx)});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Driver: apply one cycle of inputs at the falling edge and predict
    task automatic drive(input int e, input int m, input int ld, input int lv,
                         input int we, input int a, input int d);
        @(negedge clk);
        bus.en       = e[0];
        bus.mode     = m[1:0];
        bus.load     = ld[0];
        bus.load_val = W'(lv);
        bus.tbl_we   = we[0];
        bus.tbl_addr = AW'(a);
        bus.tbl_data = W'(d);
        model_step(e, m, ld, lv, we, a, d);
    endtask

    task automatic set_idle();
        bus.en = 1'b0;
        bus.mode = 2'b00;
        bus.load = 1'b0;
        bus.load_val = '0;
        bus.tbl_we = 1'b0;
        bus.tbl_addr = '0;
        bus.tbl_data = '0;
    endtask

    // Look at the outputs just after the edge that consumes the last drive
    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_q"}, int'(bus.q), 0);
        check({name, "_tc"}, int'(bus.tc), 0);
        check({name, "_idx"}, int'(bus.idx), 0);
    endtask

    // Synchronous-style reset window with a load and a table write held
    // during it; both must be discarded.
    task automatic reset_window(input string name);
        @(negedge clk);
        rst = 1'b1;
        bus.load = 1'b1;
        bus.load_val = W'(5);
        bus.tbl_we = 1'b1;
        bus.tbl_addr = AW'(0);
        bus.tbl_data = W'(7);
        @(posedge clk);
        #1;
        check_outputs_zero(name);
        @(negedge clk);
        set_idle();
        rst = 1'b0;
        model_reset();
    endtask

    // Reset raised between edges: outputs must clear before the next edge
    task automatic async_reset_mid(input string name);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_outputs_zero(name);
        bus.load = 1'b1;
        bus.load_val = W'(6);
        bus.tbl_we = 1'b1;
        bus.tbl_addr = AW'(1);
        bus.tbl_data = W'(4);
        @(posedge clk);
        #1;
        check_outputs_zero({name, "_held"});
        @(negedge clk);
        set_idle();
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: compare every predicted edge
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({bus.q, bus.tc, bus.idx} !== e) begin
                    errors++;
                    $display("FAIL out q=%0d tc=%0d idx=%0d expected q=%0d tc=%0d idx=%0d",
                             bus.q, bus.tc, bus.idx, e[EW-1 -: W], e[AW], e[AW-1:0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int tbl_vals[6];
        int mode_r;
        tbl_vals = '{5, 3, 6, 1, 7, 2};
        rst = 1'b1;
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Binary up from reset: 1..7,0,1 with tc on the wrap
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            if (i == 7) begin
                after_edge();
                check("up_wrap_q", int'(bus.q), 0);
                check("up_wrap_tc", int'(bus.tc), 1);
            end
        end

        // Load 3 with en high, then count down through the wrap
        drive(1, 1, 1, 3, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0);
            if (i == 3) begin
                after_edge();
                check("down_wrap_q", int'(bus.q), 7);
                check("down_wrap_tc", int'(bus.tc), 1);
            end
        end

        // Gray up from reset
        reset_window("reset_gray");
        for (int i = 0; i < 8; i++) drive(1, 2, 0, 0, 0, 0, 0);
        after_edge();
        check("gray_wrap_q", int'(bus.q), 0);
        check("gray_wrap_tc", int'(bus.tc), 1);

        // Program the table, including writes beyond DEPTH that must be ignored
        for (int a = 0; a < 6; a++) drive(0, 3, 0, 0, 1, a, tbl_vals[a]);
        drive(0, 3, 0, 0, 1, 6, 4);
        drive(0, 3, 0, 0, 1, 7, 0);
        for (int i = 0; i < D; i++) drive(1, 3, 0, 0, 0, 0, 0);
        after_edge();
        check("tbl_wrap_q", int'(bus.q), 5);
        check("tbl_wrap_idx", int'(bus.idx), 0);
        check("tbl_wrap_tc", int'(bus.tc), 1);

        // Write the entry being stepped into: old value now, new one next pass
        drive(1, 3, 0, 0, 0, 0, 0);
        drive(1, 3, 0, 0, 0, 0, 0);
        drive(1, 3, 0, 0, 1, 3, 4);
        after_edge();
        check("tbl_rw_old_q", int'(bus.q), 1);
        for (int i = 0; i < D; i++) drive(1, 3, 0, 0, 0, 0, 0);
        after_edge();
        check("tbl_rw_new_q", int'(bus.q), 4);
        check("tbl_rw_new_idx", int'(bus.idx), 3);

        // Mid-count asynchronous reset restores identity table
        drive(1, 3, 0, 0, 0, 0, 0);
        async_reset_mid("areset");
        for (int i = 0; i < D + 1; i++) drive(1, 3, 0, 0, 0, 0, 0);

        // Mode switch without extra latency, Gray step from a non-Gray load
        drive(0, 2, 1, 5, 0, 0, 0);
        drive(1, 2, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 3, 0, 0, 0, 0, 0);
        drive(0, 3, 0, 0, 0, 0, 0);

        // Randomized traffic
        mode_r = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) mode_r = $urandom_range(0, 3);
            if (i == 300) async_reset_mid("areset_rand");
            drive(($urandom_range(0, 3) != 0) ? 1 : 0, mode_r,
                  ($urandom_range(0, 9) == 0) ? 1 : 0, $urandom_range(0, N - 1),
                  ($urandom_range(0, 2) == 0) ? 1 : 0, $urandom_range(0, 7),
                  $urandom_range(0, N - 1));
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        check("drain_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
